// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the FSM state encoding, the branch-condition codes, the HALT opcode,
// the default instruction-store depth and the branch-condition evaluator.
package instr_sequencer_pkg;

    localparam int DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    // Opcode that ends a run; it is also the branch form with condition 111.
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Branch conditions, carried in OPcode[2:0] when OPcode[3] is set.
    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_NZ     = 3'b010;
    localparam logic [2:0] COND_N      = 3'b011;
    localparam logic [2:0] COND_NN     = 3'b100;
    localparam logic [2:0] COND_C      = 3'b101;
    localparam logic [2:0] COND_V      = 3'b110;
    localparam logic [2:0] COND_HALT   = 3'b111;

    // Evaluate a branch condition against flags {N,Z,C,V}.
    // HALT never redirects the PC; the run simply ends.
    function automatic logic branch_taken(input logic [2:0] cond, input logic [3:0] flags);
        logic taken_s;
        case (cond)
            COND_ALWAYS: taken_s = 1'b1;
            COND_Z:      taken_s = flags[2];
            COND_NZ:     taken_s = ~flags[2];
            COND_N:      taken_s = flags[3];
            COND_NN:     taken_s = ~flags[3];
            COND_C:      taken_s = flags[1];
            COND_V:      taken_s = flags[0];
            COND_HALT:   taken_s = 1'b0;
            default:     taken_s = 1'b0;
        endcase
        return taken_s;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction store: DEPTH x 8 bits, synchronous write, asynchronous read.
// Contents are deliberately not reset so a program survives a sequencer reset.
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
module instr_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_r [DEPTH];

    // Write port: one byte per enabled clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loads instruction bytes from a UART receiver into a
// small store while idle, then on Start fetches and executes them at two
// cycles per instruction, resolving conditional branches on the ALU flags.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   RxData, RxValid     instruction byte {opcode, operand} and its qualifier
//   Start, Clear        run request pulse / discard loaded program (IDLE only)
//   Flags               ALU flags {N,Z,C,V}
//   OPcode, Operand, en instruction presented to decode, with execute strobe
//   PC, LoadCount       current instruction address, number of stored bytes
//   Busy, Done          running indicator, one-cycle end-of-run pulse
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    input  logic              Start,
    input  logic              Clear,
    input  logic [3:0]        Flags,
    output logic [3:0]        OPcode,
    output logic [3:0]        Operand,
    output logic              en,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W:0]   LoadCount,
    output logic              Busy,
    output logic              Done
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_r;
    logic [7:0]        rd_data_s;
    logic              full_s;
    logic              wr_en_s;
    logic              taken_s;
    logic              halt_s;
    logic              wrap_s;
    logic              run_end_s;
    logic [ADDR_W:0]   pc_inc_s;
    logic [ADDR_W:0]   next_pc_s;

    // Writes only land while idle, not full, and not overridden by Clear.
    assign full_s  = (LoadCount == DEPTH_CNT);
    assign wr_en_s = (state_r == ST_IDLE) && RxValid && !Clear && !full_s;

    instr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (LoadCount[ADDR_W-1:0]),
        .wdata (RxData),
        .raddr (PC),
        .rdata (rd_data_s)
    );

    // Next-PC computation is one bit wider than PC so that stepping past the
    // last address is visible and can end the run instead of wrapping.
    assign taken_s   = OPcode[3] && branch_taken(OPcode[2:0], Flags);
    assign halt_s    = (OPcode == OP_HALT);
    assign pc_inc_s  = {1'b0, PC} + {{ADDR_W{1'b0}}, 1'b1};
    assign next_pc_s = taken_s ? {1'b0, ADDR_W'(Operand)} : pc_inc_s;
    assign wrap_s    = !taken_s && (PC == LAST_ADDR);
    assign run_end_s = halt_s || wrap_s || (next_pc_s >= LoadCount);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            OPcode    <= 4'h0;
            Operand   <= 4'h0;
            en        <= 1'b0;
            PC        <= {ADDR_W{1'b0}};
            LoadCount <= {(ADDR_W + 1){1'b0}};
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            en   <= 1'b0;
            Done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Clear) begin
                        LoadCount <= {(ADDR_W + 1){1'b0}};
                    end else if (wr_en_s) begin
                        LoadCount <= LoadCount + {{ADDR_W{1'b0}}, 1'b1};
                    end else begin
                        LoadCount <= LoadCount;
                    end
                    // A Clear in the same cycle discards the program, so it
                    // also suppresses the run request.
                    if (Start && !Clear && (LoadCount != {(ADDR_W + 1){1'b0}})) begin
                        PC      <= {ADDR_W{1'b0}};
                        Busy    <= 1'b1;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    OPcode  <= rd_data_s[7:4];
                    Operand <= rd_data_s[3:0];
                    en      <= 1'b1;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (run_end_s) begin
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        PC      <= next_pc_s[ADDR_W-1:0];
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    Busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: expected execute strobes are queued
// when a program is launched and compared as the DUT produces them.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] RxData = 8'h00;
    logic       RxValid = 1'b0;
    logic       Start = 1'b0;
    logic       Clear = 1'b0;
    logic [3:0] Flags = 4'h0;
    logic [3:0] OPcode;
    logic [3:0] Operand;
    logic       en;
    logic [3:0] PC;
    logic [4:0] LoadCount;
    logic       Busy;
    logic       Done;

    instr_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .RxData    (RxData),
        .RxValid   (RxValid),
        .Start     (Start),
        .Clear     (Clear),
        .Flags     (Flags),
        .OPcode    (OPcode),
        .Operand   (Operand),
        .en        (en),
        .PC        (PC),
        .LoadCount (LoadCount),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int op;
        int opd;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        RxData  = b;
        RxValid = 1'b1;
        tick();
        RxValid = 1'b0;
    endtask

    task automatic clear_prog();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
    endtask

    task automatic push_exp(input int pc, input logic [7:0] b, input int cyc);
        exp_t e;
        e.pc  = pc;
        e.op  = int'(b[7:4]);
        e.opd = int'(b[3:0]);
        e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    // Launch the loaded program and compare every en pulse with the queue.
    // With noise set, Start and RxValid are held high while the run is busy.
    task automatic run_prog(input string tag, input logic [3:0] f, input int done_cyc,
                            input bit noise);
        exp_t e;
        bit   finished;
        Flags = f;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        finished = 1'b0;
        if (noise) begin
            Start   = 1'b1;
            RxValid = 1'b1;
            RxData  = 8'hF0;
        end
        for (int cyc = 1; cyc <= 60 && !finished; cyc++) begin
            if (cyc == 1) check_val({tag, " busy_start"}, {31'd0, Busy}, 32'd1);
            if (en) begin
                if (sb_q.size() == 0) begin
                    check_val({tag, " extra_en"}, sb_q.size(), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_val({tag, " pc"}, {28'd0, PC}, e.pc);
                    check_val({tag, " opcode"}, {28'd0, OPcode}, e.op);
                    check_val({tag, " operand"}, {28'd0, Operand}, e.opd);
                    check_val({tag, " en_cycle"}, cyc, e.cyc);
                end
            end
            if (Done) begin
                Start   = 1'b0;
                RxValid = 1'b0;
                check_val({tag, " done_cycle"}, cyc, done_cyc);
                check_val({tag, " busy_end"}, {31'd0, Busy}, 32'd0);
                finished = 1'b1;
            end else begin
                tick();
            end
        end
        Start   = 1'b0;
        RxValid = 1'b0;
        if (!finished) check_val({tag, " timeout"}, {31'd0, finished}, 32'd1);
        check_val({tag, " sb_empty"}, sb_q.size(), 32'd0);
        sb_q.delete();
        tick();
    endtask

    logic [6:0] taken_lo = 7'b0010101;  // flags 0000, cond 0..6
    logic [6:0] taken_hi = 7'b1101011;  // flags 1111, cond 0..6

    initial begin
        logic [7:0] bv;
        bit         tk;
        int         en_seen;

        // Reset state
        tick();
        tick();
        check_val("rst_opcode", {28'd0, OPcode}, 32'd0);
        check_val("rst_operand", {28'd0, Operand}, 32'd0);
        check_val("rst_en", {31'd0, en}, 32'd0);
        check_val("rst_pc", {28'd0, PC}, 32'd0);
        check_val("rst_loadcount", {27'd0, LoadCount}, 32'd0);
        check_val("rst_busy", {31'd0, Busy}, 32'd0);
        check_val("rst_done", {31'd0, Done}, 32'd0);
        rst = 1'b0;
        tick();

        // Straight-line program, then re-run with Start/RxValid noise mid-run
        load_byte(8'h00);
        load_byte(8'h11);
        load_byte(8'h22);
        check_val("load3_count", {27'd0, LoadCount}, 32'd3);
        push_exp(0, 8'h00, 2);
        push_exp(1, 8'h11, 4);
        push_exp(2, 8'h22, 6);
        run_prog("linear", 4'h0, 7, 1'b0);
        check_val("linear_count", {27'd0, LoadCount}, 32'd3);
        push_exp(0, 8'h00, 2);
        push_exp(1, 8'h11, 4);
        push_exp(2, 8'h22, 6);
        run_prog("rerun", 4'h0, 7, 1'b1);
        check_val("rerun_count", {27'd0, LoadCount}, 32'd3);

        // Branch on Z, taken and not taken
        clear_prog();
        load_byte(8'h00);
        load_byte(8'h93);
        load_byte(8'h11);
        load_byte(8'h22);
        push_exp(0, 8'h00, 2);
        push_exp(1, 8'h93, 4);
        push_exp(3, 8'h22, 6);
        run_prog("bz_taken", 4'b0100, 7, 1'b0);
        push_exp(0, 8'h00, 2);
        push_exp(1, 8'h93, 4);
        push_exp(2, 8'h11, 6);
        push_exp(3, 8'h22, 8);
        run_prog("bz_not", 4'b0000, 9, 1'b0);

        // Every branch condition with all flags clear and all flags set
        for (int c = 0; c < 7; c++) begin
            for (int fs = 0; fs < 2; fs++) begin
                clear_prog();
                bv = {1'b1, 3'(c), 4'h2};
                load_byte(bv);
                load_byte(8'h11);
                load_byte(8'h22);
                tk = (fs == 1) ? taken_hi[c] : taken_lo[c];
                push_exp(0, bv, 2);
                if (tk) begin
                    push_exp(2, 8'h22, 4);
                    run_prog($sformatf("cond%0d_f%0d", c, fs), (fs == 1) ? 4'hF : 4'h0, 5, 1'b0);
                end else begin
                    push_exp(1, 8'h11, 4);
                    push_exp(2, 8'h22, 6);
                    run_prog($sformatf("cond%0d_f%0d", c, fs), (fs == 1) ? 4'hF : 4'h0, 7, 1'b0);
                end
            end
        end

        // Fill the store, drop a 17th byte (a HALT that would clobber address 0),
        // and run off the end of memory.
        clear_prog();
        for (int i = 0; i < 17; i++) begin
            bv = (i < 16) ? {1'b0, 3'(i % 8), 4'(i)} : 8'hF0;
            load_byte(bv);
        end
        check_val("full_count", {27'd0, LoadCount}, 32'd16);
        for (int i = 0; i < 16; i++) begin
            bv = {1'b0, 3'(i % 8), 4'(i)};
            push_exp(i, bv, 2 + 2 * i);
        end
        run_prog("wrap", 4'h0, 33, 1'b0);
        check_val("wrap_count", {27'd0, LoadCount}, 32'd16);

        // HALT at address 0
        clear_prog();
        check_val("clear_count", {27'd0, LoadCount}, 32'd0);
        load_byte(8'hF0);
        push_exp(0, 8'hF0, 2);
        run_prog("halt", 4'h0, 3, 1'b0);

        // Start with an empty store is ignored
        clear_prog();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_val("empty_start_busy", {31'd0, Busy}, 32'd0);
        tick();
        check_val("empty_start_en", {31'd0, en}, 32'd0);

        // Reset during EXEC of the second instruction
        load_byte(8'h00);
        load_byte(8'h11);
        load_byte(8'h22);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        check_val("pre_rst_en", {31'd0, en}, 32'd1);
        check_val("pre_rst_pc", {28'd0, PC}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_en", {31'd0, en}, 32'd0);
        check_val("mid_rst_pc", {28'd0, PC}, 32'd0);
        check_val("mid_rst_opcode", {28'd0, OPcode}, 32'd0);
        check_val("mid_rst_operand", {28'd0, Operand}, 32'd0);
        check_val("mid_rst_count", {27'd0, LoadCount}, 32'd0);
        check_val("mid_rst_busy", {31'd0, Busy}, 32'd0);
        check_val("mid_rst_done", {31'd0, Done}, 32'd0);
        en_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (en) en_seen++;
        end
        check_val("post_rst_en_count", en_seen, 32'd0);

        // Clear beats RxValid in the same cycle
        load_byte(8'h11);
        load_byte(8'h22);
        check_val("pre_clear_count", {27'd0, LoadCount}, 32'd2);
        RxData  = 8'h33;
        RxValid = 1'b1;
        Clear   = 1'b1;
        tick();
        RxValid = 1'b0;
        Clear   = 1'b0;
        check_val("clear_vs_rx_count", {27'd0, LoadCount}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the instruction-store entries; ADDR_W = log2(DEPTH) = 4.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 RxData  input  8  SHALL carry one instruction byte from the UART receiver: [7:4] opcode, [3:0] operand.
REQ-005 RxValid  input  1  SHALL qualify RxData for one cycle per byte.
REQ-006 Start  input  1  SHALL be a one-cycle pulse requesting program execution.
REQ-007 Clear  input  1  SHALL discard the loaded program when IDLE.
REQ-008 Flags  input  4  SHALL be the ALU flag register, {N,Z,C,V} (bit 3 = N).
REQ-009 OPcode  output  4  SHALL be the opcode presented to the decode stage.
REQ-010 Operand  output  4  SHALL be the operand / branch target of the current instruction.
REQ-011 en  output  1  SHALL be the execute strobe to the decode stage, high for exactly one cycle per executed instruction.
REQ-012 PC  output  ADDR_W  SHALL be the address of the current instruction.
REQ-013 LoadCount  output  ADDR_W+1  SHALL be the number of stored instructions (0..DEPTH).
REQ-014 Busy  output  1  SHALL be high in FETCH and EXEC.
REQ-015 Done  output  1  SHALL pulse one cycle when a run terminates.

Function
REQ-016 States SHALL be IDLE, FETCH, EXEC; the only transitions are IDLE->FETCH, FETCH->EXEC, EXEC->FETCH and EXEC->IDLE.
REQ-017 IDLE, RxValid=1, LoadCount<DEPTH: byte SHALL be written at address LoadCount[ADDR_W-1:0] and LoadCount incremented.
REQ-018 IDLE, RxValid=1, LoadCount=DEPTH: byte SHALL be dropped, with no state change.
REQ-019 RxValid outside IDLE SHALL be ignored.
REQ-020 IDLE, Clear=1: LoadCount SHALL become 0; Clear SHALL take priority over RxValid in the same cycle.
REQ-021 IDLE, Start=1, LoadCount>0: PC SHALL become 0 and the state FETCH; Start with LoadCount=0 SHALL be ignored.
REQ-022 Start in FETCH or EXEC SHALL be ignored.
REQ-023 FETCH: mem[PC] SHALL be registered into OPcode/Operand; en=0.
REQ-024 EXEC: en=1, with OPcode/Operand held stable for the cycle.
REQ-025 Execution rate SHALL be two cycles per instruction, so Flags written on the EXEC edge are valid at the next EXEC.
REQ-026 Branch (OPcode[3]=1): condition on OPcode[2:0] SHALL be 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 V, 111 HALT.
REQ-027 In EXEC, next PC SHALL be Operand for a taken branch, otherwise PC+1.
REQ-028 In EXEC, the run SHALL end (state IDLE, Done=1 next cycle, PC held) on any of: opcode 4'b1111; next PC >= LoadCount; PC+1 wrap past DEPTH-1.
REQ-029 A terminated run SHALL leave LoadCount and memory intact, so Start re-runs the same program.
REQ-030 Outside EXEC, en SHALL be 0.

Reset
REQ-031 On rst=1 at a clk edge: state=IDLE, OPcode=0, Operand=0, en=0, PC=0, LoadCount=0, Busy=0, Done=0.
REQ-032 Reset mid-run SHALL abort on the next edge with no further en pulse.
REQ-033 Instruction-store contents SHALL NOT be reset.

Structure
REQ-034 Shared package SHALL hold: state encoding, branch-condition codes, the HALT opcode 4'b1111, and the DEPTH default.
REQ-035 Instruction store SHALL be a sub-module instr_mem: DEPTH x 8, synchronous write, asynchronous read.

Verification
REQ-036 Load 0x00,0x11,0x22 then Start -> en pulses on cycles 2, 4 and 6 after Start with OPcode 0,1,2 and Operand 0,1,2; Done=1 one cycle after the third en; LoadCount=3.
REQ-037 Load 0x00,0x93,0x11,0x22 with Z=1 at the second EXEC -> PC sequence 0,1,3; instruction at address 2 never executed.
REQ-038 Same program with Z=0 -> PC sequence 0,1,2,3.
REQ-039 Load 17 bytes -> LoadCount=16, 17th byte dropped; then 0xF0 at address 0 with Start -> exactly one en, then Done.
REQ-040 rst asserted during EXEC of the second instruction -> next cycle all outputs at reset values, no further en; Clear and RxValid in the same IDLE cycle -> LoadCount=0.
